adder_20: RTL and testbench

ADDER_20 -- requirements
Module: adder_20

---
 rtl/adder_20_pkg.sv | 14 +
 rtl/adder_20_full_adder.sv | 20 ++
 rtl/adder_20.sv | 70 +++++++
 tb/tb_adder_20.sv | 131 +++++++++++++
 4 files changed

// File: rtl/adder_20_pkg.sv
// Shared widths and types for the registered 3-bit ripple adder.
//   OPW       : operand width (A, B)
//   SUMW      : sum width (A + B + cin, carry-out as MSB)
//   operand_t : one operand
//   sum_t     : one registered sum
package adder_20_pkg;

  localparam int unsigned OPW  = 3;
  localparam int unsigned SUMW = 4;

  typedef logic [OPW-1:0]  operand_t;
  typedef logic [SUMW-1:0] sum_t;

endpackage : adder_20_pkg

// File: rtl/adder_20_full_adder.sv
// One-bit full adder cell used to build the ripple chain.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ ci;
  assign co       = (a & b) | (ci & half_sum);

endmodule : full_adder

// File: rtl/adder_20.sv
// Registered 3-bit adder: S = A + B + cin, one result per valid input, 1-cycle latency.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_valid       : qualifies pi6..pi0 this cycle
//   pi6..pi4       : operand A (pi6 = MSB)
//   pi3..pi1       : operand B (pi3 = MSB)
//   pi0            : carry in
//   po3..po0       : registered sum (po3 = MSB, the final carry)
//   out_valid      : sum register was loaded on the last edge
module adder_20
  import adder_20_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic pi6,
  input  logic pi5,
  input  logic pi4,
  input  logic pi3,
  input  logic pi2,
  input  logic pi1,
  input  logic pi0,
  output logic po3,
  output logic po2,
  output logic po1,
  output logic po0,
  output logic out_valid
);

  operand_t       op_a;
  operand_t       op_b;
  operand_t       bit_sum;
  logic [OPW:0]   carry;
  sum_t           sum_next;
  sum_t           sum_q;
  logic           valid_q;

  assign op_a     = {pi6, pi5, pi4};
  assign op_b     = {pi3, pi2, pi1};
  assign carry[0] = pi0;

  // Ripple chain: carry out of each cell feeds the next, last carry becomes S[3].
  for (genvar i = 0; i < OPW; i++) begin : g_ripple
    full_adder u_fa (
      .a  (op_a[i]),
      .b  (op_b[i]),
      .ci (carry[i]),
      .s  (bit_sum[i]),
      .co (carry[i+1])
    );
  end

  assign sum_next = {carry[OPW], bit_sum};

  // Sum holds unless a valid input arrives; the flag tracks whether it just loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q <= sum_next;
      end
    end
  end

  assign {po3, po2, po1, po0} = sum_q;
  assign out_valid            = valid_q;

endmodule : adder_20

// File: tb/tb_adder_20.sv
module tb_adder_20;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic pi6, pi5, pi4, pi3, pi2, pi1, pi0;
  logic po3, po2, po1, po0;
  logic out_valid;

  int checks;
  int errors;

  typedef struct {
    logic [6:0] pi;
    logic       vld;
    logic [3:0] exp_po;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[6];

  adder_20 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pi6       (pi6),
    .pi5       (pi5),
    .pi4       (pi4),
    .pi3       (pi3),
    .pi2       (pi2),
    .pi1       (pi1),
    .pi0       (pi0),
    .po3       (po3),
    .po2       (po2),
    .po1       (po1),
    .po0       (po0),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_sum(input logic [6:0] v);
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    a = {1'b0, v[6:4]};
    b = {1'b0, v[3:1]};
    c = {3'b000, v[0]};
    return a + b + c;
  endfunction

  task automatic drive(input logic [6:0] v, input logic vld);
    {pi6, pi5, pi4, pi3, pi2, pi1, pi0} = v;
    in_valid = vld;
  endtask

  task automatic check(input string name, input logic [3:0] exp_po, input logic exp_ov);
    logic [3:0] act_po;
    act_po = {po3, po2, po1, po0};
    checks++;
    if (act_po !== exp_po || out_valid !== exp_ov) begin
      errors++;
      $display("FAIL %s: po=%b out_valid=%b, required po=%b out_valid=%b",
               name, act_po, out_valid, exp_po, exp_ov);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(7'b1111111, 1'b1);

    // Directed table: basic sums, then an invalid cycle that must hold 0101.
    vecs[0] = '{pi: 7'b0000000, vld: 1'b1, exp_po: 4'b0000, exp_ov: 1'b1};
    vecs[1] = '{pi: 7'b1111111, vld: 1'b1, exp_po: 4'b1111, exp_ov: 1'b1};
    vecs[2] = '{pi: 7'b1000001, vld: 1'b1, exp_po: 4'b0101, exp_ov: 1'b1};
    vecs[3] = '{pi: 7'b0110100, vld: 1'b1, exp_po: 4'b0101, exp_ov: 1'b1};
    vecs[4] = '{pi: 7'b1111111, vld: 1'b0, exp_po: 4'b0101, exp_ov: 1'b0};
    vecs[5] = '{pi: 7'b0101010, vld: 1'b0, exp_po: 4'b0101, exp_ov: 1'b0};

    // Reset held across a clock edge with a valid input present.
    #3;
    check("reset_async", 4'b0000, 1'b0);
    @(negedge clk);
    check("reset_held_over_edge", 4'b0000, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].pi, vecs[i].vld);
      @(negedge clk);
      check($sformatf("vec%0d_pi%b", i, vecs[i].pi), vecs[i].exp_po, vecs[i].exp_ov);
    end

    // Exhaustive back-to-back sweep, one result per cycle.
    for (int i = 0; i < 128; i++) begin
      drive(7'(i), 1'b1);
      @(negedge clk);
      check($sformatf("sweep_pi%b", 7'(i)), ref_sum(7'(i)), 1'b1);
    end

    // Hold after sweep's last result (1111) with random data and in_valid=0.
    drive(7'($urandom_range(0, 127)), 1'b0);
    @(negedge clk);
    check("hold_invalid", 4'b1111, 1'b0);

    // Produce 1111, then reset between edges with a valid input pending.
    drive(7'b1111111, 1'b1);
    @(negedge clk);
    check("pre_reset_1111", 4'b1111, 1'b1);
    drive(7'b1000001, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_async", 4'b0000, 1'b0);
    @(negedge clk);
    check("mid_reset_discard", 4'b0000, 1'b0);
    rst_n = 1'b1;
    drive(7'b0000011, 1'b1);
    @(negedge clk);
    check("post_reset_first", 4'b0010, 1'b1);
    drive(7'b0000000, 1'b0);
    @(negedge clk);
    check("post_reset_hold", 4'b0010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_adder_20
